riscv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation riscv_cpu. It replaces the single-cycle "PC drives Instr combinationally" scheme with decoupled fetch:
- owns the fetch PC;
- issues pipelined requests to an instruction memory with variable latency;
- buffers returned words with their PCs in a prefetch queue;
- hands them to the decoder over a valid/ready interface.
Jump/branch redirects from the control unit flush the queue and discard in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/riscv_fetch_unit_fifo.sv | 77 +++++++
 rtl/riscv_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the riscv_fetch_unit front end.
// Optional FETCH_PERF_EN adds performance counters to riscv_fetch_unit.
package riscv_fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_VECTOR_DEFAULT = '0;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO with flush, occupancy count and
// same-cycle push/pop.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  entry_t                    push_data,
    input  logic                      pop,
    output entry_t                    head,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: PC, credit-limited requests, drop of stale
// responses after redirect, prefetch queue. FETCH_PERF_EN adds perf counters.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [XLEN-1:0]    inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_dropped
`endif
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] rsp_pc_d;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   outstanding_d;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_empty;
    entry_t          fifo_head;
    entry_t          push_entry;
    logic            req_fire;
    logic            rsp_push;
    logic            rsp_drop;
    logic            inst_pop;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};

    always_comb begin
        imem_req_valid = !reset && !redirect_valid
                         && (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid
                         && (redirect_valid || (drop_cnt_q != '0));
        rsp_push       = imem_rsp_valid && !rsp_drop;
        inst_pop       = inst_valid && inst_ready;
        push_entry     = '{instr: imem_rsp_data, pc: rsp_pc_q};
    end

    // A redirect overrides everything; requests cannot fire in that cycle.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (inst_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_empty ? '0 : fifo_head.instr;
    assign inst_pc    = fifo_empty ? '0 : fifo_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_fetched_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_dropped_q;
    logic [31:0] perf_dropped_d;

    // Pops in a redirect cycle are discarded by the consumer, so not counted.
    always_comb begin
        perf_fetched_d = perf_fetched_q
                         + 32'(inst_pop && !redirect_valid);
        perf_stall_d   = perf_stall_q + 32'(inst_ready && !inst_valid);
        perf_dropped_d = perf_dropped_q + 32'(rsp_drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Randomized bench for riscv_fetch_unit against an epoch-tagged
// memory and instruction-stream model.
module tb_riscv_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_stall;
    logic [31:0]     perf_dropped;
`endif

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_dropped   (perf_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;

    mreq_t       mq[$];
    ent_t        q[$];
    int          ep = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          since_rst = 0;
    int          rst_run = 0;
    int          first_valid_at = -1;
    logic [31:0] next_pc = '0;

    int          k_ready = 100;
    int          k_iready = 100;
    int          k_redir = 0;
    int          k_lat_min = 1;
    int          k_lat_max = 1;

    int          dut_fires = 0;
    int          dut_pops = 0;
    bit          wrap_seen = 1'b0;
    logic [31:0] last_fire_addr = '0;
    bit          want_first_pop = 1'b0;
    logic [31:0] first_pop_pc = '0;
    int          m_fetched = 0;
    int          m_stall = 0;
    int          m_dropped = 0;

    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] v;
        v = $urandom;
        if (v[31:30] == 2'b00) begin
            return 32'hFFFF_FFF0 | {28'h0, v[3:0]};
        end
        return {20'h0, v[11:0]};
    endfunction

    task automatic step(input bit rst, input bit frc, input logic [31:0] fpc);
        mreq_t r;
        ent_t  e;
        int    lat;
        int    due;
        bit    rsp;
        bit    exp_req;
        bit    fire;
        bit    pop;
        @(posedge clk);
        #1;
        cyc++;
        rsp   = 1'b0;
        reset = rst;
        if (rst) begin
            redirect_valid = 1'b0;
            imem_req_ready = 1'b0;
            inst_ready     = 1'b0;
            imem_rsp_valid = 1'b0;
        end else begin
            redirect_valid = frc || (int'($urandom_range(99)) < k_redir);
            redirect_pc    = frc ? fpc : pick_target();
            imem_req_ready = int'($urandom_range(99)) < k_ready;
            inst_ready     = int'($urandom_range(99)) < k_iready;
            if (mq.size() != 0) begin
                if (mq[0].due <= cyc) rsp = 1'b1;
            end
            imem_rsp_valid = rsp;
            imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        end
        @(negedge clk);
        if (rst) begin
            check("rst_req_valid", imem_req_valid, 0);
            if (rst_run > 0) begin
                check("rst_inst_valid", inst_valid, 0);
                check("rst_inst_pc", inst_pc, 0);
                check("rst_inst_data", inst_data, 0);
            end
            rst_run++;
            mq.delete();
            q.delete();
            next_pc        = '0;
            last_due       = cyc;
            since_rst      = 0;
            first_valid_at = -1;
            m_fetched      = 0;
            m_stall        = 0;
            m_dropped      = 0;
            return;
        end
        rst_run = 0;
        since_rst++;
        exp_req = !redirect_valid && (mq.size() + q.size() < DEPTH);
        check("req_valid", imem_req_valid, exp_req);
        if (imem_req_valid) check("req_addr", imem_req_addr, next_pc);
        check("inst_valid", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("inst_pc", inst_pc, q[0].pc);
            check("inst_data", inst_data, q[0].d);
        end
        if (inst_valid && first_valid_at < 0) first_valid_at = since_rst;
        if (imem_req_valid && imem_req_ready) begin
            dut_fires++;
            if (imem_req_addr == 32'h0 && last_fire_addr == 32'hFFFF_FFFC)
                wrap_seen = 1'b1;
            last_fire_addr = imem_req_addr;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            dut_pops++;
            if (want_first_pop) begin
                first_pop_pc   = inst_pc;
                want_first_pop = 1'b0;
            end
        end
        fire = exp_req && imem_req_ready;
        pop  = (q.size() != 0) && inst_ready;
        if (inst_ready && q.size() == 0) m_stall++;
        if (redirect_valid) begin
            if (rsp) begin
                r = mq.pop_front();
                m_dropped++;
            end
            q.delete();
            ep++;
            next_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) begin
                e = q.pop_front();
                m_fetched++;
            end
            if (rsp) begin
                r = mq.pop_front();
                if (r.ep == ep) begin
                    e.pc = r.addr;
                    e.d  = mem_word(r.addr);
                    q.push_back(e);
                end else begin
                    m_dropped++;
                end
            end
            if (fire) begin
                lat = int'($urandom_range(k_lat_max, k_lat_min));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                r.addr = next_pc;
                r.ep   = ep;
                r.due  = due;
                mq.push_back(r);
                last_due = due;
                next_pc  = next_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
    endtask

    initial begin
        do_reset();

        // 1-cycle memory, always ready: latency and throughput
        k_ready = 100; k_iready = 100; k_redir = 0;
        k_lat_min = 1; k_lat_max = 1;
        dut_pops = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
        check("first_valid_cycle", first_valid_at, 3);
        check("steady_pops", dut_pops, 18);

        // stalled decoder: credit cap
        do_reset();
        k_iready = 0;
        dut_fires = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);
        check("credit_cap_reqs", dut_fires, DEPTH);
        check("full_no_req", imem_req_valid, 0);
        check("full_valid", inst_valid, 1);

        // 3-cycle memory, redirect with 3 in flight and a response arriving
        do_reset();
        k_iready = 0; k_lat_min = 3; k_lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100);
        k_iready = 100;
        want_first_pop = 1'b1;
        step(1'b0, 1'b0, '0);
        check("redir_req_valid", imem_req_valid, 1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0);
        check("redir_first_pc", first_pop_pc, 32'h100);

        // request backpressure for 5 cycles
        k_ready = 0; k_lat_min = 1; k_lat_max = 2;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        k_ready = 100;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);

        // misaligned redirect near the top of the address space
        wrap_seen = 1'b0;
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, '0);
        check("wrap_start_addr", imem_req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check("wrap_seen", wrap_seen, 1);
`ifdef FETCH_PERF_EN
        check("perf_dropped_dir", perf_dropped, m_dropped);
`endif

        // randomized traffic with occasional resets
        k_ready = 70; k_iready = 60; k_redir = 4;
        k_lat_min = 1; k_lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(599) == 0) do_reset();
            else step(1'b0, 1'b0, '0);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stall);
        check("perf_dropped", perf_dropped, m_dropped);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
